// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Single-entry operand-fetch stage between the instruction decoder and the
// execute stage. It drives the register file read addresses and absorbs the
// register file's one-cycle registered read latency. It also covers writebacks
// that the register file read path has not yet observed, so that both source
// operands reach execute with hazard-free values.
//
// Configuration macro: OPFETCH_WB_BYPASS_EN
//   defined   : a live writeback is forwarded combinationally to out_op*,
//               and the stage never stalls for a writeback hazard.
//   undefined : there is no path from wb_data to out_op*. A live writeback
//               hit holds the instruction for one cycle. The value is then
//               taken from the late-write capture registers.
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   flush                 kill the held instruction at the next edge
//   in_valid/in_ready     decoder handshake
//   in_rs1/in_rs2/in_rd   source and destination register indices
//   in_instr              instruction word, carried unchanged
//   rf_a1/rf_a2           register file read addresses (combinational)
//   rf_r1/rf_r2           register file read data, one cycle after address
//   wb_we/wb_rd/wb_data   writeback port, shared with the register file
//   out_valid/out_ready   execute handshake
//   out_op1/out_op2       resolved operands
//   out_rd/out_instr      held destination index and instruction word
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int XLEN    = 32,
    parameter int REG_CNT = 32,
    parameter int AW      = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_instr,
    output logic [AW-1:0]   rf_a1,
    output logic [AW-1:0]   rf_a2,
    input  logic [XLEN-1:0] rf_r1,
    input  logic [XLEN-1:0] rf_r2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_instr
);

    logic            v_r;
    logic [AW-1:0]   h_rs1_r;
    logic [AW-1:0]   h_rs2_r;
    logic [AW-1:0]   h_rd_r;
    logic [XLEN-1:0] h_instr_r;
    logic            f1_r;
    logic            f2_r;
    logic [XLEN-1:0] fd1_r;
    logic [XLEN-1:0] fd2_r;

    logic            acc_s;
    logic            fire_s;
    logic            hold_s;
    logic            live1_s;
    logic            live2_s;

    // Index 0 is hardwired to zero and must never be forwarded.
    function automatic logic fwd_ok(input logic [AW-1:0] idx);
        fwd_ok = (idx != {AW{1'b0}}) && (int'(idx) < REG_CNT);
    endfunction

    // Writeback in this cycle targets a held source register.
    always_comb begin
        live1_s = wb_we && (wb_rd == h_rs1_r) && fwd_ok(h_rs1_r);
        live2_s = wb_we && (wb_rd == h_rs2_r) && fwd_ok(h_rs2_r);
    end

`ifdef OPFETCH_WB_BYPASS_EN
    assign hold_s = 1'b0;
`else
    // Without the live bypass, a hit delays the instruction by one cycle.
    // The value is then taken from the capture registers.
    assign hold_s = v_r && (live1_s || live2_s);
`endif

    assign in_ready  = !flush && (!v_r || (out_ready && !hold_s));
    assign acc_s     = in_valid && in_ready;
    assign out_valid = v_r && !hold_s;
    assign fire_s    = out_valid && out_ready;

    // While stalled, the held indices are re-read every cycle, so that rf_r*
    // always corresponds to the held instruction.
    assign rf_a1 = acc_s ? in_rs1 : h_rs1_r;
    assign rf_a2 = acc_s ? in_rs2 : h_rs2_r;

    assign out_rd    = h_rd_r;
    assign out_instr = h_instr_r;

    // Operand select: live writeback, then late-write capture, then the RF.
    always_comb begin
`ifdef OPFETCH_WB_BYPASS_EN
        if (live1_s) begin
            out_op1 = wb_data;
        end else if (f1_r) begin
            out_op1 = fd1_r;
        end else begin
            out_op1 = rf_r1;
        end
        if (live2_s) begin
            out_op2 = wb_data;
        end else if (f2_r) begin
            out_op2 = fd2_r;
        end else begin
            out_op2 = rf_r2;
        end
`else
        if (f1_r) begin
            out_op1 = fd1_r;
        end else begin
            out_op1 = rf_r1;
        end
        if (f2_r) begin
            out_op2 = fd2_r;
        end else begin
            out_op2 = rf_r2;
        end
`endif
    end

    // Held instruction, valid flag and late-write capture state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_r       <= 1'b0;
            h_rs1_r   <= {AW{1'b0}};
            h_rs2_r   <= {AW{1'b0}};
            h_rd_r    <= {AW{1'b0}};
            h_instr_r <= {XLEN{1'b0}};
            f1_r      <= 1'b0;
            f2_r      <= 1'b0;
            fd1_r     <= {XLEN{1'b0}};
            fd2_r     <= {XLEN{1'b0}};
        end else begin
            if (flush) begin
                v_r <= 1'b0;
            end else if (acc_s) begin
                v_r <= 1'b1;
            end else if (fire_s) begin
                v_r <= 1'b0;
            end else begin
                v_r <= v_r;
            end
            if (acc_s) begin
                h_rs1_r   <= in_rs1;
                h_rs2_r   <= in_rs2;
                h_rd_r    <= in_rd;
                h_instr_r <= in_instr;
            end else begin
                h_rs1_r   <= h_rs1_r;
                h_rs2_r   <= h_rs2_r;
                h_rd_r    <= h_rd_r;
                h_instr_r <= h_instr_r;
            end
            // A write on this edge is not seen by the RF read issued on it.
            f1_r  <= wb_we && (wb_rd == rf_a1) && fwd_ok(rf_a1);
            f2_r  <= wb_we && (wb_rd == rf_a2) && fwd_ok(rf_a2);
            fd1_r <= wb_data;
            fd2_r <= wb_data;
        end
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Single-entry operand-fetch stage sitting between the instruction decoder and the execute stage. It drives the register file read addresses, accounts for the register file's one-cycle registered read latency, and presents both source operands with hazard-free values. A writeback bypass covers writes that the register file read path has not yet observed. The upstream and downstream sides use valid/ready handshakes.

## Interface
- `XLEN`, 32, operand and instruction width
- `REG_CNT`, 32, number of architectural registers
- `AW`, 5, register address width

- `clk`  in  1  clock, all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `flush`  in  1  synchronous kill of the held instruction
- `in_valid`  in  1  decoder presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_rs1`, `in_rs2`, `in_rd`  in  AW  source and destination register indices
- `in_instr`  in  XLEN  instruction word, carried unchanged to the output
- `rf_a1`, `rf_a2`  out  AW  register file read addresses
- `rf_r1`, `rf_r2`  in  XLEN  register file read data, registered one cycle after the address
- `wb_we`, `wb_rd`, `wb_data`  in  1/AW/XLEN  writeback port; the same signals drive the register file write port
- `out_valid`  out  1  operands valid to execute
- `out_ready`  in  1  execute accepts
- `out_op1`, `out_op2`  out  XLEN  resolved operands
- `out_rd`  out  AW  held destination index
- `out_instr`  out  XLEN  held instruction word

## Operation
- Fire conditions:
  - `acc` = `in_valid && in_ready`.
  - `fire` = `out_valid && out_ready`.
- Held registers: `h_rs1`, `h_rs2`, `h_rd`, `h_instr`, `v`. All load on `acc`.
- `v` update:
  - `v` goes to 1 on `acc`.
  - `v` goes to 0 on `fire` when there is no `acc`.
  - Otherwise `v` holds.
- Read addresses are combinational:
  - `rf_a1` = `acc ? in_rs1 : h_rs1`.
  - `rf_a2` follows the same rule with `in_rs2` and `h_rs2`.
  - While an instruction is stalled, the register file therefore re-reads the held indices every cycle.
- Late-write capture:
  - A write on edge N is not visible in `rf_r*` during cycle N+1.
  - At every edge the stage registers `f1` <= `wb_we && wb_rd==rf_a1 && rf_a1!=0`, and `fd1` <= `wb_data`.
  - `f2` and `fd2` are the same for source 2.
- Operand select, for each source n in priority order:
  1. Live write hit (`wb_we && wb_rd==h_rsn && h_rsn!=0`): use `wb_data`. Only present when the bypass is compiled in; see Configuration.
  2. `fn`: use `fdn`.
  3. Otherwise: use `rf_rn`.
- x0 rule: index 0 never forwards. The operand for index 0 is always `rf_rn`, which the register file returns as 0.
- Flush:
  - `flush` forces `v` to 0 at the next edge and blocks `acc` in the same cycle (`in_ready` = 0 while `flush` is high).
  - Flush has priority over `fire` and `acc`.
- Reset (`reset_n`=0 at an edge):
  - `v`, `f1`, `f2` = 0.
  - Held indices, `h_instr`, `fd1`, `fd2` = 0.
  - Outputs after reset: `out_valid`=0, `out_rd`=0, `out_instr`=0, `rf_a1`=`rf_a2`=0 (while `in_valid`=0), `in_ready`=1.
  - Reset mid-stall discards the held instruction.

## Timing
- Latency: accept on edge N, `out_valid`=1 in cycle N+1. Operands are valid in the same cycle as `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready`=1.
- `in_ready` = `!flush && (!v || (out_ready && !hold))`. `hold` is 0 when the bypass is compiled in.
- Simultaneous `fire` and `acc`: new instruction is loaded and `v` stays 1.
- `out_*` are stable while `out_valid && !out_ready`. `out_op*` may change during such a stall only to reflect newer writebacks.
- `wb_rd` matching both sources: both operands forward.
- Write hits on edge N and again in cycle N+1: the live write wins.

## Configuration
- `OPFETCH_WB_BYPASS_EN` defined:
  - Priority-1 live writeback bypass is present.
  - `hold` = 0.
- `OPFETCH_WB_BYPASS_EN` undefined:
  - No combinational path from `wb_data` to `out_op*`.
  - `hold` = `v && wb_we && wb_rd!=0 && (wb_rd==h_rs1 || wb_rd==h_rs2)`.
  - `out_valid` = `v && !hold`.
  - The instruction waits one cycle and then takes the value through `fn`.
  - Each such hazard costs 1 bubble.

## Test plan
- Reset then idle: `reset_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `rf_a1`=`in_rs1` after release.
- Back-to-back stream:
  - Stimulus: x5=0x11, x6=0x22 preloaded; send `add x7,x5,x6` for 4 consecutive cycles with `out_ready`=1.
  - Required: 4 outputs on consecutive cycles, each with `op1`=0x11, `op2`=0x22.
- Late-write capture: `wb` writes x5=0xAA on the same edge that accepts an instruction reading x5 → `out_op1`=0xAA in the next cycle; with the bypass compiled out, the result is identical.
- Live write:
  - Stimulus: instruction held; `wb` writes x6=0x55 during the output cycle.
  - With the macro: `out_op2`=0x55 in the same cycle.
  - Without the macro: `out_valid`=0 that cycle, then `out_op2`=0x55 one cycle later.
- x0 and backpressure:
  - Stimulus: instruction reads x0 while `wb` writes x0=0xFF; `out_ready`=0 for 3 cycles.
  - Required: `out_op1`=0 throughout, `in_ready`=0, all `out_*` stable.
- Flush and reset mid-stall: with `v`=1 and `out_ready`=0, assert `flush` with `in_valid`=1 → `out_valid`=0 next cycle and the new instruction is not accepted. Repeating with `reset_n`=0 gives the same result.
